// File: rtl/ascon_perm_ctrl_pkg.sv
// Shared definitions for the Ascon permutation controller: round counts and FSM states.
package ascon_perm_ctrl_pkg;

  localparam int MAX_ROUNDS     = 12;
  localparam int PA_ROUNDS      = 12;
  localparam int PB_ROUNDS_128  = 6;
  localparam int PB_ROUNDS_128A = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ascon_p_core.sv
// One Ascon round per job step. The input state is captured on en_i, the round is
// evaluated from that capture on the following edge, so a round takes two cycles.
// The round-constant ROM lives here; callers provide only the round index.
module ascon_p_core #(
  parameter int BW = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en_i,
  input  logic [3:0]      round_i,
  input  logic [5*BW-1:0] s_in_i,
  output logic [5*BW-1:0] s_out_o
);

  logic [5*BW-1:0] stage_q;
  logic [3:0]      idx_q;
  logic [5*BW-1:0] result_q;
  logic [5*BW-1:0] round_out;

  logic [BW-1:0] xs  [5];
  logic [BW-1:0] sb  [5];
  logic [BW-1:0] sx  [5];
  logic [BW-1:0] lin [5];

  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'hf0;
      4'd1:    rc = 8'he1;
      4'd2:    rc = 8'hd2;
      4'd3:    rc = 8'hc3;
      4'd4:    rc = 8'hb4;
      4'd5:    rc = 8'ha5;
      4'd6:    rc = 8'h96;
      4'd7:    rc = 8'h87;
      4'd8:    rc = 8'h78;
      4'd9:    rc = 8'h69;
      4'd10:   rc = 8'h5a;
      4'd11:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [BW-1:0] ror(input logic [BW-1:0] x, input int n);
    return (x >> n) | (x << (BW - n));
  endfunction

  // Constant addition, 5-bit S-box across lanes, then per-lane linear diffusion.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      xs[k] = stage_q[(4-k)*BW +: BW];
    end
    xs[2] = xs[2] ^ BW'(round_const(idx_q));

    xs[0] = xs[0] ^ xs[4];
    xs[4] = xs[4] ^ xs[3];
    xs[2] = xs[2] ^ xs[1];

    sb[0] = xs[0] ^ (~xs[1] & xs[2]);
    sb[1] = xs[1] ^ (~xs[2] & xs[3]);
    sb[2] = xs[2] ^ (~xs[3] & xs[4]);
    sb[3] = xs[3] ^ (~xs[4] & xs[0]);
    sb[4] = xs[4] ^ (~xs[0] & xs[1]);

    sx[0] = sb[0] ^ sb[4];
    sx[1] = sb[1] ^ sb[0];
    sx[2] = ~sb[2];
    sx[3] = sb[3] ^ sb[2];
    sx[4] = sb[4];

    lin[0] = sx[0] ^ ror(sx[0], 19) ^ ror(sx[0], 28);
    lin[1] = sx[1] ^ ror(sx[1], 61) ^ ror(sx[1], 39);
    lin[2] = sx[2] ^ ror(sx[2], 1)  ^ ror(sx[2], 6);
    lin[3] = sx[3] ^ ror(sx[3], 10) ^ ror(sx[3], 17);
    lin[4] = sx[4] ^ ror(sx[4], 7)  ^ ror(sx[4], 41);

    round_out = {lin[0], lin[1], lin[2], lin[3], lin[4]};
  end

  // Capture a new round request on en_i and register the evaluated round every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      if (en_i) begin
        stage_q <= s_in_i;
        idx_q   <= round_i;
      end
      result_q <= round_out;
    end
  end

  assign s_out_o = result_q;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterates a single Ascon round core nr times over a state, with a valid/ready
// request side, a valid/ready result side and a synchronous clear.
module ascon_perm_ctrl #(
  parameter int BW         = 64,
  parameter int MAX_ROUNDS = 12
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5*BW-1:0] in_state,
  input  logic [3:0]      in_rounds,
  input  logic            clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5*BW-1:0] out_state,
  output logic            busy
);
  import ascon_perm_ctrl_pkg::*;

  state_e          state_q;
  logic [3:0]      remaining_q;
  logic [3:0]      round_q;
  logic [3:0]      round_d;
  logic [5*BW-1:0] out_state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic            accept;
  logic [3:0]      nr;
  logic            core_en;
  logic [5*BW-1:0] core_s_in;
  logic [5*BW-1:0] core_s_out;

  // Out-of-range round requests fall back to the full permutation.
  always_comb begin
    nr = in_rounds;
    if (in_rounds == 4'd0 || in_rounds > 4'(MAX_ROUNDS)) begin
      nr = 4'(MAX_ROUNDS);
    end
  end

  // Core input mux: new state on accept, feedback with next round index while iterating.
  always_comb begin
    accept    = in_valid && in_ready_q && !clear;
    core_en   = 1'b0;
    core_s_in = core_s_out;
    round_d   = round_q;
    if (accept) begin
      core_en   = 1'b1;
      core_s_in = in_state;
      round_d   = 4'(MAX_ROUNDS) - nr;
    end else if (state_q == ISSUE && remaining_q != 4'd0 && !clear) begin
      core_en = 1'b1;
      round_d = round_q + 4'd1;
    end
  end

  ascon_p_core #(
    .BW(BW)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (core_en),
    .round_i (round_d),
    .s_in_i  (core_s_in),
    .s_out_o (core_s_out)
  );

  // Controller FSM with registered handshake outputs; clear overrides every transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      round_q     <= '0;
      out_state_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      round_q <= round_d;
      if (clear) begin
        state_q     <= IDLE;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q     <= WAIT;
              remaining_q <= nr - 4'd1;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          WAIT: begin
            state_q <= ISSUE;
          end
          ISSUE: begin
            if (remaining_q == 4'd0) begin
              out_state_q <= core_s_out;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              remaining_q <= remaining_q - 4'd1;
              state_q     <= WAIT;
            end
          end
          DONE: begin
            if (out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: requests push expected results from a
// software Ascon model, a monitor pops and compares whenever a result appears.
module tb_ascon_perm_ctrl;

  localparam int BW = 64;

  typedef struct {
    logic [5*BW-1:0] state;
    int              acceptCyc;
    int              lat;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [5*BW-1:0] in_state;
  logic [3:0]      in_rounds;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [5*BW-1:0] out_state;
  logic            busy;

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;
  int lastAccept  = 0;

  exp_t            expQ[$];
  logic            vPrev;
  logic            hsPrev;
  logic [5*BW-1:0] holdState;

  ascon_perm_ctrl #(
    .BW(BW),
    .MAX_ROUNDS(12)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_rounds (in_rounds),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference-style software Ascon permutation, last nr rounds of p12.
  function automatic logic [319:0] asconModel(input logic [319:0] s, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 12 - nr; r < 12; r++) begin
      x2 ^= 64'((15 - r) * 16 + r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0; t1 = ~x1; t2 = ~x2; t3 = ~x3; t4 = ~x4;
      t0 &= x1; t1 &= x2; t2 &= x3; t3 &= x4; t4 &= x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror64(x0, 19) ^ ror64(x0, 28);
      x1 ^= ror64(x1, 61) ^ ror64(x1, 39);
      x2 ^= ror64(x2, 1)  ^ ror64(x2, 6);
      x3 ^= ror64(x3, 10) ^ ror64(x3, 17);
      x4 ^= ror64(x4, 7)  ^ ror64(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] actual, input logic [319:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one request; when track is set the model result is queued for the monitor.
  task automatic applyStimulus(input logic [319:0] st, input logic [3:0] rounds, input int expNr, input bit track);
    int   waitCnt = 0;
    bit   got = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    in_state  = st;
    in_rounds = rounds;
    in_valid  = 1'b1;
    while (!got && waitCnt < 200) begin
      @(negedge clk);
      if (in_ready) begin
        got        = 1'b1;
        lastAccept = cyc;
        if (track) begin
          e.state     = asconModel(st, expNr);
          e.acceptCyc = cyc;
          e.lat       = 2 * expNr + 1;
          expQ.push_back(e);
        end
      end else begin
        waitCnt++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("accept within budget", 320'(got), 320'd1);
  endtask

  task automatic waitDrain();
    int waitCnt = 0;
    bit done = 1'b0;
    while (!done && waitCnt < 300) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !out_valid) done = 1'b1;
      else waitCnt++;
    end
    checkOutput("drain within budget", 320'(done), 320'd1);
  endtask

  // Monitor: latency and value on every new result, stability while stalled, single handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      vPrev  = 1'b0;
      hsPrev = 1'b0;
    end else begin
      if (hsPrev) checkOutput("single handshake", 320'(out_valid), 320'd0);
      if (out_valid) begin
        checkOutput("in_ready low while result pending", 320'(in_ready), 320'd0);
        if (!vPrev) begin
          if (expQ.size() == 0) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL unexpected result: got %h expected no out_valid", out_state);
          end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("latency", 320'(cyc - e.acceptCyc), 320'(e.lat));
            checkOutput("result", out_state, e.state);
            holdState = out_state;
          end
        end else begin
          checkOutput("result stable while stalled", out_state, holdState);
        end
      end
      hsPrev = out_valid && out_ready;
      vPrev  = out_valid;
    end
  end

  logic [319:0] stA;
  logic [319:0] stB;

  initial begin
    stA = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0000000000000000,
           64'hffffffffffffffff, 64'h8040201008040201};
    stB = {64'h80400c0600000000, 64'h000102030405060f, 64'h08090a0b0c0d0e0f,
           64'hdeadbeefcafef00d, 64'h5555aaaa3333cccc};
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_rounds = 4'd0;
    clear     = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 320'(in_ready), 320'd0);
    checkOutput("reset out_valid", 320'(out_valid), 320'd0);
    checkOutput("reset busy", 320'(busy), 320'd0);
    checkOutput("reset out_state", out_state, 320'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("in_ready before first edge", 320'(in_ready), 320'd0);
    @(negedge clk);
    checkOutput("in_ready after release", 320'(in_ready), 320'd1);

    // clear together with in_valid in IDLE must not start a job
    @(posedge clk); #1;
    in_state = stA; in_rounds = 4'd12; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    checkOutput("clear blocks accept busy", 320'(busy), 320'd0);
    checkOutput("clear blocks accept in_ready", 320'(in_ready), 320'd1);

    $display("[TB] p12 on zero state");
    applyStimulus(320'd0, 4'd12, 12, 1'b1);
    waitDrain();

    $display("[TB] p6 then p8 back to back");
    applyStimulus(stA, 4'd6, 6, 1'b1);
    applyStimulus(stB, 4'd8, 8, 1'b1);
    waitDrain();

    $display("[TB] out-of-range round counts and p1");
    applyStimulus(stA, 4'd0, 12, 1'b1);
    applyStimulus(stA, 4'd15, 12, 1'b1);
    applyStimulus(stB, 4'd13, 12, 1'b1);
    applyStimulus(stB, 4'd1, 1, 1'b1);
    waitDrain();

    $display("[TB] stall consumer for 10 cycles");
    out_ready = 1'b0;
    applyStimulus(stB, 4'd8, 8, 1'b1);
    begin
      int w = 0;
      while (!out_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      checkOutput("result within budget", 320'(out_valid), 320'd1);
    end
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("idle after handshake", 320'(in_ready), 320'd1);

    $display("[TB] clear at cycle 7 of p12");
    applyStimulus(stA, 4'd12, 12, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("clear cycle index", 320'(cyc - lastAccept), 320'd7);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    checkOutput("idle after clear busy", 320'(busy), 320'd0);
    checkOutput("idle after clear in_ready", 320'(in_ready), 320'd1);
    checkOutput("idle after clear out_valid", 320'(out_valid), 320'd0);
    applyStimulus(stA, 4'd12, 12, 1'b1);
    waitDrain();

    $display("[TB] reset at cycle 5 of p12");
    applyStimulus(stB, 4'd12, 12, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("mid-job reset in_ready", 320'(in_ready), 320'd0);
    checkOutput("mid-job reset out_valid", 320'(out_valid), 320'd0);
    checkOutput("mid-job reset busy", 320'(busy), 320'd0);
    checkOutput("mid-job reset out_state", out_state, 320'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("in_ready held after release", 320'(in_ready), 320'd0);
    @(negedge clk);
    checkOutput("in_ready after mid-job reset", 320'(in_ready), 320'd1);
    applyStimulus(stB, 4'd12, 12, 1'b1);
    waitDrain();

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/ascon_perm_ctrl.md
ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

Interface
REQ-001 SHALL have parameter BW, default 64: Ascon lane width in bits; the state is 5*BW bits.
REQ-002 SHALL have parameter MAX_ROUNDS, default 12: number of rounds in the full permutation p^12.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request carries a state to permute.
REQ-006 in_ready  output  1  controller can accept a request.
REQ-007 in_state  input  5*BW  input state, lane S0 in the MSBs, S4 in the LSBs.
REQ-008 in_rounds  input  4  number of rounds to apply; legal values are 1..12.
REQ-009 clear  input  1  synchronous abort; discards the job in progress.
REQ-010 out_valid  output  1  out_state holds a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_state  output  5*BW  permuted state, same lane order as in_state.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL use FSM states IDLE, WAIT, ISSUE and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept occurs when in_valid and in_ready are both high. On accept the block SHALL:
- drive core s_in = in_state and core round = 12 - nr;
- latch nr and remaining = nr - 1;
- go to WAIT.
REQ-017 nr SHALL equal in_rounds for values 1..12; a value of 0 or greater than 12 SHALL be treated as 12.
REQ-018 WAIT SHALL last exactly 1 cycle, then go to ISSUE.
REQ-019 In ISSUE with remaining = 0, the block SHALL capture core s_out into the out_state register and go to DONE.
REQ-020 In ISSUE with remaining > 0, the block SHALL:
- drive core s_in = core s_out and core round = previous round + 1;
- decrement remaining;
- go to WAIT.
REQ-021 In all cycles other than those in REQ-016 and REQ-020, core s_in SHALL be core s_out and core round SHALL hold its last value; this value is don't-care.
REQ-022 Latency SHALL be fixed at 2 cycles per round:
- accept at cycle 0;
- out_valid first high at cycle 2*nr+1 (p12: cycle 25; p6: cycle 13; p1: cycle 3).
REQ-023 In DONE, out_state and out_valid SHALL hold stable until out_ready is sampled high; the block SHALL then return to IDLE.
REQ-024 A new request SHALL NOT be accepted in the DONE-to-IDLE handoff cycle; the earliest next accept is the cycle after the DONE exit.
REQ-025 clear SHALL move the FSM to IDLE on the next edge from any state, with priority over all other transitions.
REQ-026 clear SHALL drop out_valid and busy and discard the job.
REQ-027 If clear and in_valid are both high in IDLE, the request SHALL NOT be accepted.
REQ-028 Round index arithmetic SHALL be 4-bit unsigned and never exceeds 11 for legal nr.

Reset
REQ-029 While rstn is low:
- FSM = IDLE; in_ready = 0 during reset, 1 from the first edge after release;
- out_valid = 0; busy = 0; out_state = 0;
- remaining = 0 and round index = 0.
REQ-030 Reset asserted mid-job SHALL abandon the job with no output produced; the first accept after release behaves as from power-up.

Structure
REQ-031 A shared package SHALL hold:
- constants MAX_ROUNDS = 12, PA_ROUNDS = 12, PB_ROUNDS_128 = 6, PB_ROUNDS_128A = 8;
- the FSM state typedef.
REQ-032 SHALL instantiate exactly one ascon_p_core (BW passed through), sharing clk and rstn.
REQ-033 The ascon_p_core output SHALL feed back to its input through the controller mux.
REQ-034 The round-constant ROM SHALL stay inside ascon_p_core; the controller supplies only the 4-bit round index.

Verification
REQ-035 Verification SHALL cover these directed scenarios:
- Accept all-zero state with in_rounds=12 -> out_valid rises at cycle 25; out_state matches the software Ascon p12 model; round index sequence is 0..11.
- Accept with in_rounds=6, then in_rounds=8 -> latencies 13 and 17; start indices 6 and 4; both results match the model.
- Accept with in_rounds=0 and again with in_rounds=15 -> identical to the in_rounds=12 result and latency.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable; in_ready=0 throughout; release gives a single handshake, then IDLE.
- Pulse clear at cycle 7 of a p12 job -> IDLE at cycle 8; no out_valid; the next p12 job produces the correct result.
- Assert rstn low at cycle 5 of a job -> all outputs 0; after release, in_ready=1 and a fresh job completes correctly.
